// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweep controller and its bench.
package tt_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int N_ROWS = 8;
    localparam int ROW_W  = 3;

    // Known-good table of f: s = a & ~(b & c), bit i is row {a,b,c} = i
    localparam logic [N_ROWS-1:0] REF_F_TABLE = 8'h70;

    // A settle time of zero cycles would sample s before f has seen the new row
    function automatic int eff_settle(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/tt_sweep_ctrl.sv
// Drives f through all eight input rows, captures s per row into a truth
// table, counts the ones and compares the table with an expected value.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | waiting for start; results of the last sweep are held
//  ST_APPLY   | {a,b,c} = row held while the settle counter runs
//  ST_CAPTURE | one cycle; s is written into the table at the row index
//  ST_DONE    | one cycle; done pulse, match valid, drive returns to 000
module tt_sweep_ctrl
    import tt_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_ROWS-1:0] expected,
    input  logic              s,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              busy,
    output logic              done,
    output logic [N_ROWS-1:0] truth_table,
    output logic [3:0]        ones,
    output logic              match
);

    localparam int SETTLE_EFF = eff_settle(SETTLE);
    localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);

    state_t              state,   state_n;
    logic [ROW_W-1:0]    row_q,   row_n;
    logic [ROW_W-1:0]    drive_q, drive_n;
    logic [CNT_W-1:0]    cnt_q,   cnt_n;
    logic [N_ROWS-1:0]   tbl_q,   tbl_n;
    logic [N_ROWS-1:0]   exp_q,   exp_n;
    logic [3:0]          ones_q,  ones_n;
    logic                match_q, match_n;

    // State and datapath registers; reset discards any sweep in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            row_q   <= '0;
            drive_q <= '0;
            cnt_q   <= '0;
            tbl_q   <= '0;
            exp_q   <= '0;
            ones_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state   <= state_n;
            row_q   <= row_n;
            drive_q <= drive_n;
            cnt_q   <= cnt_n;
            tbl_q   <= tbl_n;
            exp_q   <= exp_n;
            ones_q  <= ones_n;
            match_q <= match_n;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_n = state;
        row_n   = row_q;
        drive_n = drive_q;
        cnt_n   = cnt_q;
        tbl_n   = tbl_q;
        exp_n   = exp_q;
        ones_n  = ones_q;
        match_n = match_q;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_APPLY;
                    row_n   = '0;
                    drive_n = '0;
                    cnt_n   = '0;
                    tbl_n   = '0;
                    ones_n  = '0;
                    match_n = 1'b0;
                    exp_n   = expected;
                end
            end
            ST_APPLY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_CAPTURE;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                tbl_n[row_q] = s;
                ones_n       = ones_q + {3'b000, s};
                if (row_q != ROW_LAST) begin
                    row_n   = row_q + 1'b1;
                    drive_n = row_q + 1'b1;
                    state_n = ST_APPLY;
                end else begin
                    // tbl_n already holds the final row here
                    match_n = (tbl_n == exp_q);
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                drive_n = '0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign a           = drive_q[2];
    assign b           = drive_q[1];
    assign c           = drive_q[0];
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign truth_table = tbl_q;
    assign ones        = ones_q;
    assign match       = match_q;

endmodule
